// File: rtl/mccomp_ctrl_fsm_pkg.sv
// Shared definitions for the multicycle MIPS control FSM: state encodings,
// opcode/funct constants, ALU function codes and datapath mux select codes.
package mccomp_ctrl_fsm_pkg;

    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB_R     = 4'd7,
        S_EXEC_I   = 4'd8,
        S_WB_I     = 4'd9,
        S_WB_LW    = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12,
        S_JUMP_R   = 4'd13,
        S_TRAP     = 4'd14
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_LUI  = 4'd10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_A     = 2'b01;
    localparam logic [1:0] SRCA_SHAMT = 2'b10;

    localparam logic [1:0] SRCB_B   = 2'b00;
    localparam logic [1:0] SRCB_4   = 2'b01;
    localparam logic [1:0] SRCB_IMM = 2'b10;
    localparam logic [1:0] SRCB_BR  = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_A      = 2'b11;

    localparam logic [1:0] DST_RT  = 2'b00;
    localparam logic [1:0] DST_RD  = 2'b01;
    localparam logic [1:0] DST_R31 = 2'b10;

    localparam logic [1:0] WD_ALUOUT = 2'b00;
    localparam logic [1:0] WD_MDR    = 2'b01;
    localparam logic [1:0] WD_PC     = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] wd_sel;
        logic       ext_op;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic [1:0] pc_src;
        logic       retire;
        logic       trap;
    } ctrl_t;

    // States that stall on mem_ready and are subject to the wait timeout.
    function automatic logic is_mem_state(state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

    function automatic logic [3:0] imm_alu_op(logic [5:0] op);
        case (op)
            OP_SLTI: return ALU_SLT;
            OP_ANDI: return ALU_AND;
            OP_ORI:  return ALU_OR;
            OP_LUI:  return ALU_LUI;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mccomp_ctrl_fsm_alu_dec.sv
// R-type funct decoder: ALU function code, shift-amount operand select and
// an illegal-funct flag for the control FSM.
module mccomp_alu_dec
    import mccomp_ctrl_fsm_pkg::*;
(
    input  logic [5:0] i_funct,
    output logic [3:0] o_alu_op,
    output logic       o_shamt,
    output logic       o_illegal
);

    always_comb begin
        o_alu_op  = ALU_ADD;
        o_shamt   = 1'b0;
        o_illegal = 1'b0;
        case (i_funct)
            FN_SLL:          begin o_alu_op = ALU_SLL; o_shamt = 1'b1; end
            FN_SRL:          begin o_alu_op = ALU_SRL; o_shamt = 1'b1; end
            FN_JR:           o_alu_op = ALU_ADD;
            FN_ADD, FN_ADDU: o_alu_op = ALU_ADD;
            FN_SUB, FN_SUBU: o_alu_op = ALU_SUB;
            FN_AND:          o_alu_op = ALU_AND;
            FN_OR:           o_alu_op = ALU_OR;
            FN_XOR:          o_alu_op = ALU_XOR;
            FN_NOR:          o_alu_op = ALU_NOR;
            FN_SLT:          o_alu_op = ALU_SLT;
            FN_SLTU:         o_alu_op = ALU_SLTU;
            default:         o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mccomp_ctrl_fsm.sv
// Multicycle MIPS control FSM: sequences the shared ALU/memory datapath,
// waits on memory, traps on illegal opcodes or memory timeout, counts retires.
module mccomp_ctrl_fsm #(
    parameter int WAIT_TIMEOUT = 16,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ir_write,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic [1:0]       reg_dst,
    output logic [1:0]       wd_sel,
    output logic             ext_op,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [3:0]       alu_op,
    output logic [1:0]       pc_src,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic             trap,
    output logic [3:0]       state_o
);
    import mccomp_ctrl_fsm_pkg::*;

    // Counter only has to reach WAIT_TIMEOUT-1: the stall cycle at that count is the last one.
    localparam int                WCNT_W     = (WAIT_TIMEOUT < 2) ? 1 : $clog2(WAIT_TIMEOUT);
    localparam logic [WCNT_W-1:0] WAIT_LAST  = WCNT_W'(WAIT_TIMEOUT - 1);
    localparam logic              TIMEOUT_EN = (WAIT_TIMEOUT != 0);

    state_t            r_state;
    state_t            w_next;
    logic [WCNT_W-1:0] r_wait;
    logic [CNT_W-1:0]  r_instret;
    ctrl_t             w_ctrl;
    logic              w_stall;
    logic              w_timeout;
    logic [3:0]        w_fn_alu;
    logic              w_fn_shamt;
    logic              w_fn_illegal;

    mccomp_alu_dec u_alu_dec (
        .i_funct   (funct),
        .o_alu_op  (w_fn_alu),
        .o_shamt   (w_fn_shamt),
        .o_illegal (w_fn_illegal)
    );

    assign w_stall   = is_mem_state(r_state) && !mem_ready;
    assign w_timeout = TIMEOUT_EN && w_stall && (r_wait == WAIT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_RESET;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   r_wait <= '0;
        else if (w_next != r_state) r_wait <= '0;
        else if (TIMEOUT_EN && w_stall) r_wait <= r_wait + WCNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)               r_instret <= '0;
        else if (w_ctrl.retire) r_instret <= r_instret + CNT_W'(1);
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RESET:  w_next = S_FETCH;
            S_FETCH:  if (mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_RTYPE: begin
                        if (funct == FN_JR)    w_next = S_JUMP_R;
                        else if (w_fn_illegal) w_next = S_TRAP;
                        else                   w_next = S_EXEC_R;
                    end
                    OP_LW, OP_SW:                               w_next = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:                             w_next = S_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_LUI:  w_next = S_EXEC_I;
                    OP_J, OP_JAL:                               w_next = S_JUMP;
                    default:                                    w_next = S_TRAP;
                endcase
            end
            S_EXEC_R:   w_next = S_WB_R;
            S_EXEC_I:   w_next = S_WB_I;
            S_MEM_ADDR: w_next = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_ready) w_next = S_WB_LW;
            S_MEM_WR:   if (mem_ready) w_next = S_FETCH;
            S_WB_R, S_WB_I, S_WB_LW,
            S_BRANCH, S_JUMP, S_JUMP_R: w_next = S_FETCH;
            S_TRAP:     w_next = S_TRAP;
            default:    w_next = S_RESET;
        endcase
        if (w_timeout) w_next = S_TRAP;
    end

    always_comb begin
        w_ctrl = '0;
        case (r_state)
            S_FETCH: begin
                w_ctrl.mem_read  = 1'b1;
                w_ctrl.alu_src_b = SRCB_4;
                w_ctrl.ir_write  = mem_ready;
                w_ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                w_ctrl.ext_op    = 1'b1;
                w_ctrl.alu_src_b = SRCB_BR;
            end
            S_EXEC_R: begin
                w_ctrl.alu_src_a = w_fn_shamt ? SRCA_SHAMT : SRCA_A;
                w_ctrl.alu_src_b = SRCB_B;
                w_ctrl.alu_op    = w_fn_alu;
            end
            S_EXEC_I: begin
                w_ctrl.alu_src_a = SRCA_A;
                w_ctrl.alu_src_b = SRCB_IMM;
                w_ctrl.ext_op    = !(op == OP_ANDI || op == OP_ORI);
                w_ctrl.alu_op    = imm_alu_op(op);
            end
            S_MEM_ADDR: begin
                w_ctrl.alu_src_a = SRCA_A;
                w_ctrl.alu_src_b = SRCB_IMM;
                w_ctrl.ext_op    = 1'b1;
            end
            S_MEM_RD: begin
                w_ctrl.mem_read = 1'b1;
                w_ctrl.iord     = 1'b1;
            end
            S_MEM_WR: begin
                w_ctrl.mem_write = 1'b1;
                w_ctrl.iord      = 1'b1;
                w_ctrl.retire    = mem_ready;
            end
            S_WB_R: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.reg_dst   = DST_RD;
                w_ctrl.wd_sel    = WD_ALUOUT;
                w_ctrl.retire    = 1'b1;
            end
            S_WB_I, S_WB_LW: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.reg_dst   = DST_RT;
                w_ctrl.wd_sel    = (r_state == S_WB_LW) ? WD_MDR : WD_ALUOUT;
                w_ctrl.retire    = 1'b1;
            end
            S_BRANCH: begin
                w_ctrl.alu_src_a = SRCA_A;
                w_ctrl.alu_src_b = SRCB_B;
                w_ctrl.alu_op    = ALU_SUB;
                w_ctrl.pc_src    = PCSRC_ALUOUT;
                w_ctrl.pc_write  = (op == OP_BNE) ? !zero : zero;
                w_ctrl.retire    = 1'b1;
            end
            S_JUMP: begin
                // PC was already advanced by 4 during fetch, so jal links straight from PC.
                w_ctrl.pc_src    = PCSRC_JUMP;
                w_ctrl.pc_write  = 1'b1;
                w_ctrl.reg_write = (op == OP_JAL);
                w_ctrl.reg_dst   = (op == OP_JAL) ? DST_R31 : DST_RT;
                w_ctrl.wd_sel    = (op == OP_JAL) ? WD_PC : WD_ALUOUT;
                w_ctrl.retire    = 1'b1;
            end
            S_JUMP_R: begin
                w_ctrl.pc_src   = PCSRC_A;
                w_ctrl.pc_write = 1'b1;
                w_ctrl.retire   = 1'b1;
            end
            S_TRAP:  w_ctrl.trap = 1'b1;
            default: w_ctrl = '0;
        endcase
        // The stall cycle that times out must not leave a request dangling.
        if (w_timeout) begin
            w_ctrl.mem_read  = 1'b0;
            w_ctrl.mem_write = 1'b0;
            w_ctrl.ir_write  = 1'b0;
            w_ctrl.pc_write  = 1'b0;
        end
    end

    assign pc_write  = w_ctrl.pc_write;
    assign ir_write  = w_ctrl.ir_write;
    assign iord      = w_ctrl.iord;
    assign mem_read  = w_ctrl.mem_read;
    assign mem_write = w_ctrl.mem_write;
    assign reg_write = w_ctrl.reg_write;
    assign reg_dst   = w_ctrl.reg_dst;
    assign wd_sel    = w_ctrl.wd_sel;
    assign ext_op    = w_ctrl.ext_op;
    assign alu_src_a = w_ctrl.alu_src_a;
    assign alu_src_b = w_ctrl.alu_src_b;
    assign alu_op    = w_ctrl.alu_op;
    assign pc_src    = w_ctrl.pc_src;
    assign retire    = w_ctrl.retire;
    assign trap      = w_ctrl.trap;
    assign instret   = r_instret;
    assign state_o   = r_state;

endmodule
